img_buf_pp: RTL and testbench
=============================

IMG_BUF_PP -- requirements
Module: img_buf_pp

Interface
REQ-001 Parameter IMG_W, default 8, image width in pixels (even, >=4).
REQ-002 Parameter IMG_H, default 8, image height in pixels (even, >=4).
REQ-003 Parameter PIX_W, default 8, pixel width in bits.
REQ-004 Parameter COORD_W, default 10, coordinate width in bits.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wr_valid  input  1  write pixel present.
REQ-008 wr_ready  output  1  write bank can accept a pixel.
REQ-009 wr_x, wr_y  input  COORD_W each  write coordinate.
REQ-010 wr_pixel  input  PIX_W  write data.
REQ-011 rd_frame_ready  output  1  a complete frame is readable.
REQ-012 rd_valid  input  1  read request for the 2x2 neighbourhood at (rx,ry).
REQ-013 rx, ry  input  COORD_W each  read coordinate (upper-left pixel).
REQ-014 rd_release  input  1  single-cycle pulse; reader finished with the current frame.
REQ-015 out_valid  output  1  lu/ru/ld/rd hold the result of one request.
REQ-016 lu, ru, ld, rd  output  PIX_W each  neighbourhood pixels: left/right, up/down.

Function
REQ-017 Storage: two frame banks (ping-pong); each bank split into four parity memories by (y[0],x[0]), so four neighbours are read in one cycle.
REQ-018 Memory address = {bank, (y>>1)*(IMG_W/2) + (x>>1)}; depth per memory = IMG_W*IMG_H/2.
REQ-019 State: full[1:0] flags, wr_bank and rd_bank pointers, all 1 bit.
REQ-020 wr_ready = !full[wr_bank]; a write is accepted when wr_valid && wr_ready.
REQ-021 Accepted write with wr_x>=IMG_W or wr_y>=IMG_H is dropped without a memory write or flag change.
REQ-022 Accepted write at (IMG_W-1, IMG_H-1) sets full[wr_bank] and toggles wr_bank in the same edge.
REQ-023 rd_frame_ready = full[rd_bank]; rd_valid is ignored (no out_valid) while rd_frame_ready=0.
REQ-024 rd_release with full[rd_bank]=1 clears full[rd_bank] and toggles rd_bank; it is ignored otherwise.
REQ-025 Same-edge last-write and rd_release act on different banks, or the write is blocked; both take effect with no lost update.
REQ-026 Requests accepted in the rd_release cycle complete from the old bank.
REQ-027 Read clamping: cx=min(rx,IMG_W-1), cy=min(ry,IMG_H-1); right column = min(cx+1,IMG_W-1); down row = min(cy+1,IMG_H-1).
REQ-028 Hence at the right edge ru=lu and rd=ld; at the bottom edge ld=lu and rd=ru.
REQ-029 Read latency is fixed at 2 cycles: request at edge N gives out_valid and data after edge N+2. Throughput is one request per cycle, with no back-pressure.
REQ-030 Parity routing uses the request's (cy[0],cx[0]) delayed 1 cycle, aligned with memory output.
REQ-031 lu/ru/ld/rd hold their value when out_valid=0.

Reset
REQ-032 On rst: full=00, wr_bank=0, rd_bank=0, out_valid=0, lu=ru=ld=rd=0, pipeline valid bits cleared.
REQ-033 Reset mid-frame discards partial frames; memory contents are not cleared; in-flight reads produce no out_valid.

Structure
REQ-034 Shared package rect_pkg holds PIX_W, COORD_W defaults and the parity-index constants (LU/RU/LD/RD select codes).
REQ-035 Memories are four instances of the existing bram_sd (1-cycle read, re tied high); no other sub-module.
REQ-036 Address and clamp arithmetic are combinational; one pipeline register stage sits after the memories.

Verification (IMG_W=IMG_H=8, pixel=y*8+x)
REQ-037 Write full frame raster -> full=01, wr_bank=1, rd_frame_ready=1; read (2,4) -> 2 cycles later lu=34 ru=35 ld=42 rd=43, out_valid=1.
REQ-038 Read (7,3) -> lu=31 ru=31 ld=39 rd=39; read (7,7) -> all 63; read (12,20) -> all 63.
REQ-039 Write frame 2 (pixel+100) while frame 1 is read, then write frame 3 -> wr_ready=0 at frame 3 start; frame 1 data unchanged; rd_release -> rd_bank=1, read (0,0) -> lu=100, wr_ready=1 next cycle.
REQ-040 Back-to-back reads (1,1),(2,1),(1,2) on consecutive cycles -> three consecutive out_valid cycles, lu=9,10,17.
REQ-041 rst asserted after 20 writes and one pending read -> no out_valid, rd_frame_ready=0, wr_ready=1; rd_release with no full frame -> no state change.
REQ-042 Write to (8,0) and (0,9) during fill -> frame contents and full flags unaffected.

Source files
------------

// File: rtl/rect_pkg.sv
// Shared constants and types for the ping-pong image buffer: default widths,
// parity-memory select codes and the read-tag record carried beside the memories.
package rect_pkg;

  localparam int PIX_W_DEF   = 8;
  localparam int COORD_W_DEF = 10;

  // Memory index is {y[0], x[0]}; each neighbour code is the parity flip
  // applied to the upper-left pixel's index to reach that neighbour.
  localparam logic [1:0] SEL_LU = 2'd0;
  localparam logic [1:0] SEL_RU = 2'd1;
  localparam logic [1:0] SEL_LD = 2'd2;
  localparam logic [1:0] SEL_RD = 2'd3;

  typedef struct packed {
    logic cx0;
    logic cy0;
    logic x_edge;
    logic y_edge;
  } rd_tag_t;

  function automatic logic [1:0] par_sel(input logic y0, input logic x0);
    return {y0, x0};
  endfunction

endpackage

// File: rtl/bram_sd.sv
// Simple dual-port block RAM: one write port, one registered read port
// with a single cycle of read latency.
module bram_sd #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/img_buf_pp.sv
// Ping-pong frame buffer: one bank fills while the other is read as clamped
// 2x2 neighbourhoods, one request per cycle with a fixed two-cycle latency.
module img_buf_pp
  import rect_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [PIX_W-1:0]   wr_pixel,
  output logic               rd_frame_ready,
  input  logic               rd_valid,
  input  logic [COORD_W-1:0] rx,
  input  logic [COORD_W-1:0] ry,
  input  logic               rd_release,
  output logic               out_valid,
  output logic [PIX_W-1:0]   lu,
  output logic [PIX_W-1:0]   ru,
  output logic [PIX_W-1:0]   ld,
  output logic [PIX_W-1:0]   rd
);

  localparam int CELL_AW = $clog2(IMG_W * IMG_H / 4);
  localparam int MEM_AW  = CELL_AW + 1;
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(IMG_H - 1);

  function automatic logic [CELL_AW-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
    logic [2*COORD_W-1:0] lin;
    lin = {{COORD_W{1'b0}}, 1'b0, y[COORD_W-1:1]} * (2*COORD_W)'(IMG_W / 2)
        + {{COORD_W{1'b0}}, 1'b0, x[COORD_W-1:1]};
    return lin[CELL_AW-1:0];
  endfunction

  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic       wr_en, wr_last, rel;

  assign wr_ready       = !full_q[wr_bank_q];
  assign rd_frame_ready = full_q[rd_bank_q];

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_en     = wr_valid && wr_ready && (wr_x <= X_MAX) && (wr_y <= Y_MAX);
    wr_last   = (wr_x == X_MAX) && (wr_y == Y_MAX);
    rel       = rd_release && full_q[rd_bank_q];
    // A write to the bank being released is impossible (it is full), so both updates compose.
    if (wr_en && wr_last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  logic [COORD_W-1:0] cx, cy, xr, yd;
  logic               x_edge, y_edge;
  logic [MEM_AW-1:0]  rd_addr [4];
  logic [MEM_AW-1:0]  wr_addr;
  logic [3:0]         we_vec;
  logic [PIX_W-1:0]   mem_rdata [4];

  always_comb begin
    logic [1:0] mi;
    mi     = 2'd0;
    cx     = (rx > X_MAX) ? X_MAX : rx;
    cy     = (ry > Y_MAX) ? Y_MAX : ry;
    x_edge = (cx == X_MAX);
    y_edge = (cy == Y_MAX);
    xr     = x_edge ? cx : cx + COORD_W'(1);
    yd     = y_edge ? cy : cy + COORD_W'(1);
    wr_addr = {wr_bank_q, cell_addr(wr_x, wr_y)};
    // Each parity memory reads whichever of the four neighbour coordinates has its parity.
    for (int m = 0; m < 4; m++) begin
      mi         = 2'(m);
      rd_addr[m] = {rd_bank_q, cell_addr((cx[0] == mi[0]) ? cx : xr,
                                         (cy[0] == mi[1]) ? cy : yd)};
      we_vec[m]  = wr_en && (par_sel(wr_y[0], wr_x[0]) == mi);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_mem
    bram_sd #(
      .DW(PIX_W),
      .AW(MEM_AW)
    ) u_mem (
      .clk  (clk),
      .we   (we_vec[g]),
      .waddr(wr_addr),
      .wdata(wr_pixel),
      .re   (1'b1),
      .raddr(rd_addr[g]),
      .rdata(mem_rdata[g])
    );
  end

  logic       req_v_q, req_v_d;
  rd_tag_t    tag_q, tag_d;
  logic       out_valid_q, out_valid_d;
  logic [PIX_W-1:0] lu_q, lu_d, ru_q, ru_d, ld_q, ld_d, rd_q, rd_d;
  logic [1:0] lu_idx, flip_mask;

  always_comb begin
    req_v_d     = rd_valid && full_q[rd_bank_q];
    tag_d       = '{cx0: cx[0], cy0: cy[0], x_edge: x_edge, y_edge: y_edge};
    out_valid_d = req_v_q;
    lu_d        = lu_q;
    ru_d        = ru_q;
    ld_d        = ld_q;
    rd_d        = rd_q;
    lu_idx      = par_sel(tag_q.cy0, tag_q.cx0);
    // At a clamped edge the neighbour shares the upper-left parity, so its flip is suppressed.
    flip_mask   = ~{tag_q.y_edge, tag_q.x_edge};
    if (req_v_q) begin
      lu_d = mem_rdata[lu_idx ^ (SEL_LU & flip_mask)];
      ru_d = mem_rdata[lu_idx ^ (SEL_RU & flip_mask)];
      ld_d = mem_rdata[lu_idx ^ (SEL_LD & flip_mask)];
      rd_d = mem_rdata[lu_idx ^ (SEL_RD & flip_mask)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_v_q     <= 1'b0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      lu_q        <= '0;
      ru_q        <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
    end else begin
      req_v_q     <= req_v_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      lu_q        <= lu_d;
      ru_q        <= ru_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign lu        = lu_q;
  assign ru        = ru_q;
  assign ld        = ld_q;
  assign rd        = rd_q;

endmodule

// File: tb/tb_img_buf_pp.sv
// Self-checking bench for img_buf_pp: randomized writes/reads compared against a
// frame-level reference model (two pixel arrays plus full flags and bank pointers).
module tb_img_buf_pp;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int PW = 8;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [CW-1:0] wr_x, wr_y;
  logic [PW-1:0] wr_pixel;
  logic          rd_frame_ready;
  logic          rd_valid;
  logic [CW-1:0] rx, ry;
  logic          rd_release;
  logic          out_valid;
  logic [PW-1:0] lu, ru, ld, rd;

  always #5 clk = ~clk;

  img_buf_pp #(
    .IMG_W(W), .IMG_H(H), .PIX_W(PW), .COORD_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
    .rd_frame_ready(rd_frame_ready), .rd_valid(rd_valid), .rx(rx), .ry(ry),
    .rd_release(rd_release), .out_valid(out_valid),
    .lu(lu), .ru(ru), .ld(ld), .rd(rd)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PW-1:0] m_mem [2][W*H];
  bit            m_full [2];
  bit            m_wb, m_rb;
  bit            p1_v;
  logic [PW-1:0] p1_lu, p1_ru, p1_ld, p1_rd;
  bit            e_ov;
  logic [PW-1:0] e_lu, e_ru, e_ld, e_rd;

  int            rq_x [4] = '{2, 7, 7, 12};
  int            rq_y [4] = '{4, 3, 7, 20};
  logic [PW-1:0] rq_exp [4][4] = '{'{8'd34, 8'd35, 8'd42, 8'd43},
                                   '{8'd31, 8'd31, 8'd39, 8'd39},
                                   '{8'd63, 8'd63, 8'd63, 8'd63},
                                   '{8'd63, 8'd63, 8'd63, 8'd63}};

  task automatic calc_read(input bit bank, input int x, input int y,
                           output logic [PW-1:0] a, output logic [PW-1:0] b,
                           output logic [PW-1:0] c, output logic [PW-1:0] d);
    int cx, cy, xr, yd;
    cx = (x > W-1) ? W-1 : x;
    cy = (y > H-1) ? H-1 : y;
    xr = (cx + 1 > W-1) ? W-1 : cx + 1;
    yd = (cy + 1 > H-1) ? H-1 : cy + 1;
    a = m_mem[bank][cy*W + cx];
    b = m_mem[bank][cy*W + xr];
    c = m_mem[bank][yd*W + cx];
    d = m_mem[bank][yd*W + xr];
  endtask

  // Advance one clock edge, applying the same edge's effects to the model, then settle.
  task automatic cycle();
    bit rel;
    @(posedge clk);
    if (rst) begin
      m_full[0] = 0; m_full[1] = 0; m_wb = 0; m_rb = 0;
      p1_v = 0; e_ov = 0;
      e_lu = '0; e_ru = '0; e_ld = '0; e_rd = '0;
    end else begin
      e_ov = p1_v;
      if (p1_v) begin
        e_lu = p1_lu; e_ru = p1_ru; e_ld = p1_ld; e_rd = p1_rd;
      end
      rel  = rd_release && m_full[m_rb];
      p1_v = rd_valid && m_full[m_rb];
      if (p1_v) calc_read(m_rb, int'(rx), int'(ry), p1_lu, p1_ru, p1_ld, p1_rd);
      if (wr_valid && !m_full[m_wb] && wr_x < W && wr_y < H) begin
        m_mem[m_wb][int'(wr_y)*W + int'(wr_x)] = wr_pixel;
        if (wr_x == W-1 && wr_y == H-1) begin
          m_full[m_wb] = 1;
          m_wb = !m_wb;
        end
      end
      if (rel) begin
        m_full[m_rb] = 0;
        m_rb = !m_rb;
      end
    end
    #1;
  endtask

  task automatic drive_write(input int x, input int y, input logic [PW-1:0] pix);
    wr_valid = 1'b1; wr_x = CW'(x); wr_y = CW'(y); wr_pixel = pix;
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic drive_read(input int x, input int y);
    rd_valid = 1'b1; rx = CW'(x); ry = CW'(y);
    cycle();
    rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_ready got %0b want 1", wr_ready); end
    checks++;
    if (rd_frame_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_ready got %0b want 0", rd_frame_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if ({lu, ru, ld, rd} !== 32'h0) begin errors++; $display("[TB] FAIL reset_pixels got %h want 0", {lu, ru, ld, rd}); end
  endtask

  task automatic test_fill_and_read();
    for (int i = 0; i < W*H; i++) begin
      if (i == 40) drive_write(8, 0, 8'hEE);
      if (i == 50) drive_write(0, 9, 8'hDD);
      if (i == 20) begin
        checks++;
        if (rd_frame_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_early_ready got %0b want 0", rd_frame_ready); end
      end
      repeat ($urandom_range(0, 1)) cycle();
      drive_write(i % W, i / W, PW'(i));
    end
    checks++;
    if (rd_frame_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_frame_ready got %0b want 1", rd_frame_ready); end
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_wr_ready got %0b want 1", wr_ready); end
    for (int k = 0; k < 4; k++) begin
      drive_read(rq_x[k], rq_y[k]);
      cycle();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL read%0d_valid got %0b want 1", k, out_valid); end
      checks++;
      if ({lu, ru, ld, rd} !== {rq_exp[k][0], rq_exp[k][1], rq_exp[k][2], rq_exp[k][3]})
        begin errors++; $display("[TB] FAIL read%0d_pixels got %0d %0d %0d %0d want %0d %0d %0d %0d", k, lu, ru, ld, rd,
                                 rq_exp[k][0], rq_exp[k][1], rq_exp[k][2], rq_exp[k][3]); end
      cycle();
      checks++;
      if (out_valid !== 1'b0 || lu !== rq_exp[k][0])
        begin errors++; $display("[TB] FAIL read%0d_hold got valid %0b lu %0d want valid 0 lu %0d", k, out_valid, lu, rq_exp[k][0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] want_lu [3] = '{8'd9, 8'd10, 8'd17};
    rd_valid = 1'b1; rx = CW'(1); ry = CW'(1);
    cycle();
    rx = CW'(2); ry = CW'(1);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin rx = CW'(1); ry = CW'(2); end
      if (k == 2) rd_valid = 1'b0;
      cycle();
      checks++;
      if (out_valid !== 1'b1 || lu !== want_lu[k])
        begin errors++; $display("[TB] FAIL b2b%0d got valid %0b lu %0d want valid 1 lu %0d", k, out_valid, lu, want_lu[k]); end
      checks++;
      if ({lu, ru, ld, rd} !== {e_lu, e_ru, e_ld, e_rd})
        begin errors++; $display("[TB] FAIL b2b%0d_model got %h want %h", k, {lu, ru, ld, rd}, {e_lu, e_ru, e_ld, e_rd}); end
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_random_reads();
    for (int i = 0; i < 40; i++) begin
      rd_valid = 1'($urandom);
      rx = CW'($urandom_range(0, 11));
      ry = CW'($urandom_range(0, 11));
      cycle();
      checks++;
      if (out_valid !== e_ov || {lu, ru, ld, rd} !== {e_lu, e_ru, e_ld, e_rd})
        begin errors++; $display("[TB] FAIL rand_read%0d got %0b %h want %0b %h", i, out_valid, {lu, ru, ld, rd}, e_ov, {e_lu, e_ru, e_ld, e_rd}); end
    end
    rd_valid = 1'b0;
  endtask

  task automatic test_pingpong();
    for (int i = 0; i < W*H + 2; i++) begin
      wr_valid = (i < W*H);
      wr_x = CW'(i % W); wr_y = CW'(i / W); wr_pixel = PW'(i + 100);
      rd_valid = 1'($urandom);
      rx = CW'($urandom_range(0, 9));
      ry = CW'($urandom_range(0, 9));
      cycle();
      checks++;
      if (out_valid !== e_ov || {lu, ru, ld, rd} !== {e_lu, e_ru, e_ld, e_rd})
        begin errors++; $display("[TB] FAIL pp_read%0d got %0b %h want %0b %h", i, out_valid, {lu, ru, ld, rd}, e_ov, {e_lu, e_ru, e_ld, e_rd}); end
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    wr_valid = 1'b1; wr_x = '0; wr_y = '0; wr_pixel = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL pp_blocked%0d got %0b want 0", k, wr_ready); end
      cycle();
    end
    wr_valid = 1'b0;
    drive_read(2, 4);
    cycle();
    checks++;
    if (lu !== 8'd34 || rd !== 8'd43) begin errors++; $display("[TB] FAIL pp_frame1_kept got %0d %0d want 34 43", lu, rd); end
    rd_release = 1'b1;
    cycle();
    rd_release = 1'b0;
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL pp_release_wr_ready got %0b want 1", wr_ready); end
    checks++;
    if (rd_frame_ready !== 1'b1) begin errors++; $display("[TB] FAIL pp_release_frame_ready got %0b want 1", rd_frame_ready); end
    drive_read(0, 0);
    cycle();
    checks++;
    if (out_valid !== 1'b1 || {lu, ru, ld, rd} !== {8'd100, 8'd101, 8'd108, 8'd109})
      begin errors++; $display("[TB] FAIL pp_frame2_read got %0b %0d %0d %0d %0d want 1 100 101 108 109", out_valid, lu, ru, ld, rd); end
  endtask

  task automatic test_same_edge();
    for (int i = 0; i < W*H - 1; i++) drive_write(i % W, i / W, PW'($urandom));
    wr_valid = 1'b1; wr_x = CW'(W-1); wr_y = CW'(H-1); wr_pixel = PW'($urandom);
    rd_release = 1'b1; rd_valid = 1'b1; rx = CW'(3); ry = CW'(3);
    cycle();
    wr_valid = 1'b0; rd_release = 1'b0; rd_valid = 1'b0;
    checks++;
    if (rd_frame_ready !== 1'b1) begin errors++; $display("[TB] FAIL same_edge_frame_ready got %0b want 1", rd_frame_ready); end
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL same_edge_wr_ready got %0b want 1", wr_ready); end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || lu !== 8'd127 || rd !== 8'd136)
      begin errors++; $display("[TB] FAIL same_edge_old_bank got %0b %0d %0d want 1 127 136", out_valid, lu, rd); end
    drive_read(5, 6);
    cycle();
    checks++;
    if ({lu, ru, ld, rd} !== {e_lu, e_ru, e_ld, e_rd})
      begin errors++; $display("[TB] FAIL same_edge_frame3 got %h want %h", {lu, ru, ld, rd}, {e_lu, e_ru, e_ld, e_rd}); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 20; i++) drive_write(i % W, i / W, PW'($urandom));
    drive_read(1, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid%0d got %0b want 0", k, out_valid); end
      cycle();
    end
    checks++;
    if (rd_frame_ready !== 1'b0 || wr_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL mid_reset_flags got ready %0b wr %0b want 0 1", rd_frame_ready, wr_ready); end
    rd_release = 1'b1;
    cycle();
    rd_release = 1'b0;
    checks++;
    if (rd_frame_ready !== 1'b0 || wr_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL idle_release got ready %0b wr %0b want 0 1", rd_frame_ready, wr_ready); end
    for (int i = 0; i < W*H; i++) drive_write(i % W, i / W, PW'(i) ^ 8'h3C);
    checks++;
    if (rd_frame_ready !== 1'b1) begin errors++; $display("[TB] FAIL refill_ready got %0b want 1", rd_frame_ready); end
    drive_read(3, 5);
    cycle();
    checks++;
    if (out_valid !== 1'b1 || {lu, ru, ld, rd} !== {8'd43 ^ 8'h3C, 8'd44 ^ 8'h3C, 8'd51 ^ 8'h3C, 8'd52 ^ 8'h3C})
      begin errors++; $display("[TB] FAIL refill_read got %0b %h", out_valid, {lu, ru, ld, rd}); end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_pixel = '0;
    rd_valid = 1'b0; rx = '0; ry = '0; rd_release = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < W*H; i++) m_mem[b][i] = '0;
    test_reset();
    test_fill_and_read();
    test_back_to_back();
    test_random_reads();
    test_pingpong();
    test_same_edge();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
